// File: rtl/bsg_downstream_in.sv
// ---------------------------------------------------------------------------
// bsg_downstream_in
//
// Receive end of the BSG off-chip two-channel byte link. Each beat from the
// io side carries two bytes (ch0, ch1). Four accepted beats are rebuilt into
// one 64-bit core word. Completed words go into a small first-word-fall-
// through FIFO, which the core drains over a valid/ready handshake.
//
// Handshake rules (both sides):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The sender holds its data stable while valid is 1 and ready is 0.
//   io_ready depends only on registered state, so it has no combinational
//   path from io_valid_in or core_ready_in.
//
// Beat-to-byte map (k = beat_cnt):
//   k=0: ch0 -> [7:0],   ch1 -> [23:16]
//   k=1: ch0 -> [15:8],  ch1 -> [31:24]
//   k=2: ch0 -> [39:32], ch1 -> [55:48]
//   k=3: ch0 -> [47:40], ch1 -> [63:56]
//
// Ports:
//   clk             single clock
//   rst             synchronous, active-low reset
//   io_valid_in     beat valid from link
//   io_data_in_ch0  channel 0 byte of the current beat
//   io_data_in_ch1  channel 1 byte of the current beat
//   io_ready        block can accept a beat this cycle (FIFO not full)
//   core_valid_out  FIFO head word valid
//   core_data_out   FIFO head word, 0 when the FIFO is empty
//   core_ready_in   core accepts the head word
//   beat_cnt        index of the next expected beat (beat FSM state)
//   protocol_err    sticky flag: a beat was presented while io_ready was 0
//
// Parameter:
//   FIFO_DEPTH      assembled-word FIFO entries, power of two in 2..8
// ---------------------------------------------------------------------------
module bsg_downstream_in #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_valid_in,
    input  logic [7:0]  io_data_in_ch0,
    input  logic [7:0]  io_data_in_ch1,
    output logic        io_ready,
    output logic        core_valid_out,
    output logic [63:0] core_data_out,
    input  logic        core_ready_in,
    output logic [1:0]  beat_cnt,
    output logic        protocol_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Beat FSM: the state is the index of the next beat of the current word.
    typedef enum logic [1:0] {
        BEAT0 = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        BEAT3 = 2'd3
    } beat_state_t;

    beat_state_t state_q;
    beat_state_t state_d;

    logic             beat_accept;
    logic             push;
    logic             pop;
    logic [63:0]      asm_q;
    logic [63:0]      asm_d;

    logic [63:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             perr_q;

    // -----------------------------------------------------------------------
    // io side
    // -----------------------------------------------------------------------
    assign io_ready    = (count_q < DEPTH_C);
    assign beat_accept = io_valid_in & io_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= BEAT0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next beat index and push strobe. The last beat of a word pushes the
    // completed word into the FIFO at the same edge that accepts it.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        if (beat_accept) begin
            case (state_q)
                BEAT0: state_d = BEAT1;
                BEAT1: state_d = BEAT2;
                BEAT2: state_d = BEAT3;
                BEAT3: begin
                    state_d = BEAT0;
                    push    = 1'b1;
                end
                default: state_d = BEAT0;
            endcase
        end
    end

    // Assembly register with the current beat merged in. asm_d is also the
    // word written to the FIFO on the last beat, so the final two bytes do
    // not need an extra cycle to land in asm_q first.
    always_comb begin
        asm_d = asm_q;
        if (beat_accept) begin
            case (state_q)
                BEAT0: begin
                    asm_d[7:0]   = io_data_in_ch0;
                    asm_d[23:16] = io_data_in_ch1;
                end
                BEAT1: begin
                    asm_d[15:8]  = io_data_in_ch0;
                    asm_d[31:24] = io_data_in_ch1;
                end
                BEAT2: begin
                    asm_d[39:32] = io_data_in_ch0;
                    asm_d[55:48] = io_data_in_ch1;
                end
                BEAT3: begin
                    asm_d[47:40] = io_data_in_ch0;
                    asm_d[63:56] = io_data_in_ch1;
                end
                default: asm_d = asm_q;
            endcase
        end
    end

    // A partial word simply waits here while io_ready is low; bytes are only
    // overwritten by accepted beats, so nothing is lost or duplicated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            asm_q <= '0;
        end else begin
            asm_q <= asm_d;
        end
    end

    // Sticky: any beat offered while the FIFO is full is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else if (io_valid_in && !io_ready) begin
            perr_q <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Word FIFO (FWFT). Pointers wrap naturally because the depth is a power
    // of two; the extra count bit distinguishes full from empty.
    // -----------------------------------------------------------------------
    assign core_valid_out = (count_q != '0);
    assign pop            = core_valid_out & core_ready_in;

    // Storage needs no reset: an entry is only read after it has been written,
    // and the output mux forces zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= asm_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // push only happens when not full and pop only when not empty, so the
    // count stays inside 0..FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // No same-cycle bypass: a word pushed into an empty FIFO shows up on the
    // cycle after its last beat.
    assign core_data_out = core_valid_out ? mem[rd_ptr_q] : 64'd0;

    assign beat_cnt      = state_q;
    assign protocol_err  = perr_q;

endmodule

// File: tb/tb_bsg_downstream_in.sv
// ---------------------------------------------------------------------------
// tb_bsg_downstream_in
//
// Bench for bsg_downstream_in. A word-level model (byte positions computed
// arithmetically, a queue of completed words) predicts every output on every
// cycle; a few literal expectations pin the model in the directed scenarios.
// Inputs change 1 time unit after the rising edge; outputs are compared and
// the model advanced on the falling edge.
// ---------------------------------------------------------------------------
module tb_bsg_downstream_in;

  localparam int DEPTH = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        io_valid_in;
  logic [7:0]  io_data_in_ch0;
  logic [7:0]  io_data_in_ch1;
  logic        io_ready;
  logic        core_valid_out;
  logic [63:0] core_data_out;
  logic        core_ready_in;
  logic [1:0]  beat_cnt;
  logic        protocol_err;

  bsg_downstream_in #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .io_valid_in    (io_valid_in),
    .io_data_in_ch0 (io_data_in_ch0),
    .io_data_in_ch1 (io_data_in_ch1),
    .io_ready       (io_ready),
    .core_valid_out (core_valid_out),
    .core_data_out  (core_data_out),
    .core_ready_in  (core_ready_in),
    .beat_cnt       (beat_cnt),
    .protocol_err   (protocol_err)
  );

  int total = 0;
  int bad   = 0;

  // behavioural model state
  logic [63:0] exp_q[$];
  logic [63:0] m_part;
  int          m_k;
  bit          m_perr;
  bit          m_live = 1'b0;

  // literal expectations, written by the stimulus process only
  bit          lit_data_en  = 1'b0;
  logic [63:0] lit_data;
  bit          lit_ready_en = 1'b0;
  logic        lit_ready;
  bit          lit_perr_en  = 1'b0;
  logic        lit_perr;
  bit          lit_beat_en  = 1'b0;
  logic [1:0]  lit_beat;
  bit          tmo_req      = 1'b0;

  // byte lane of channel ch for beat k
  function automatic int byte_pos(input int k, input int ch);
    int lo;
    lo = (k < 2) ? k : k + 2;
    return lo + 2 * ch;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    bit          m_ready;
    bit          m_pop;
    logic [63:0] exp_data;
    m_ready  = (exp_q.size() < DEPTH);
    exp_data = (exp_q.size() > 0) ? exp_q[0] : 64'd0;
    if (m_live) begin
      chk("io_ready", 64'(io_ready), 64'(m_ready));
      chk("core_valid_out", 64'(core_valid_out), 64'(exp_q.size() > 0));
      chk("core_data_out", core_data_out, exp_data);
      chk("beat_cnt", 64'(beat_cnt), 64'(m_k));
      chk("protocol_err", 64'(protocol_err), 64'(m_perr));
    end
    if (lit_data_en)  chk("lit_core_data", core_data_out, lit_data);
    if (lit_ready_en) chk("lit_io_ready", 64'(io_ready), 64'(lit_ready));
    if (lit_perr_en)  chk("lit_protocol_err", 64'(protocol_err), 64'(lit_perr));
    if (lit_beat_en)  chk("lit_beat_cnt", 64'(beat_cnt), 64'(lit_beat));
    if (tmo_req) begin
      total++;
      bad++;
      $display("FAIL io_ready_wait timed out at t=%0t", $time);
    end
    // advance the model over the coming rising edge
    if (rst === 1'b0) begin
      exp_q.delete();
      m_part = 64'd0;
      m_k    = 0;
      m_perr = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      m_pop = (exp_q.size() > 0) && (core_ready_in === 1'b1);
      if (io_valid_in && !m_ready) m_perr = 1'b1;
      if (m_pop) void'(exp_q.pop_front());
      if (io_valid_in && m_ready) begin
        m_part[8*byte_pos(m_k, 0) +: 8] = io_data_in_ch0;
        m_part[8*byte_pos(m_k, 1) +: 8] = io_data_in_ch1;
        if (m_k == 3) exp_q.push_back(m_part);
        m_k = (m_k + 1) % 4;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    lit_data_en  = 1'b0;
    lit_ready_en = 1'b0;
    lit_perr_en  = 1'b0;
    lit_beat_en  = 1'b0;
    tmo_req      = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] c0, input logic [7:0] c1);
    int n;
    n = 0;
    io_valid_in = 1'b0;
    while (io_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) tmo_req = 1'b1;
    io_valid_in    = 1'b1;
    io_data_in_ch0 = c0;
    io_data_in_ch1 = c1;
    tick();
    io_valid_in = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int k = 0; k < 4; k++) begin
      send_beat(w[8*byte_pos(k, 0) +: 8], w[8*byte_pos(k, 1) +: 8]);
    end
  endtask

  logic [63:0] w [10];
  logic [7:0]  t1_c0 [4];
  logic [7:0]  t1_c1 [4];
  bit          gap_pat [7];

  initial begin
    int b;
    for (int i = 0; i < 10; i++) w[i] = {$urandom(), $urandom()};
    t1_c0   = '{8'h00, 8'h11, 8'h44, 8'h55};
    t1_c1   = '{8'h22, 8'h33, 8'h66, 8'h77};
    gap_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst            = 1'b0;
    io_valid_in    = 1'b0;
    io_data_in_ch0 = 8'h00;
    io_data_in_ch1 = 8'h00;
    core_ready_in  = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    // first cycle after reset
    lit_ready_en = 1'b1; lit_ready = 1'b1;
    lit_data_en  = 1'b1; lit_data  = 64'd0;
    lit_beat_en  = 1'b1; lit_beat  = 2'd0;
    lit_perr_en  = 1'b1; lit_perr  = 1'b0;
    tick();

    // 1: basic word
    core_ready_in = 1'b1;
    for (int k = 0; k < 4; k++) send_beat(t1_c0[k], t1_c1[k]);
    lit_data_en = 1'b1; lit_data = 64'h7766_5544_3322_1100;
    tick();
    tick();

    // 2: core held off, three words, FIFO depth 2
    core_ready_in = 1'b0;
    send_word(w[1]);
    send_word(w[2]);
    for (int i = 0; i < 3; i++) begin
      lit_ready_en = 1'b1; lit_ready = 1'b0;
      lit_beat_en  = 1'b1; lit_beat  = 2'd0;
      tick();
    end
    core_ready_in = 1'b1;
    lit_data_en = 1'b1; lit_data = w[1];
    tick();
    lit_data_en  = 1'b1; lit_data  = w[2];
    lit_ready_en = 1'b1; lit_ready = 1'b1;
    tick();
    send_word(w[3]);
    lit_data_en = 1'b1; lit_data = w[3];
    tick();
    tick();

    // 3: valid gaps
    b = 0;
    for (int i = 0; i < 7; i++) begin
      lit_beat_en = 1'b1; lit_beat = 2'(b);
      io_valid_in = gap_pat[i];
      if (gap_pat[i]) begin
        io_data_in_ch0 = t1_c0[b];
        io_data_in_ch1 = t1_c1[b];
        b++;
      end
      tick();
    end
    io_valid_in = 1'b0;
    lit_data_en = 1'b1; lit_data = 64'h7766_5544_3322_1100;
    tick();
    tick();

    // 4: beats offered while full
    core_ready_in = 1'b0;
    send_word(w[4]);
    send_word(w[5]);
    io_valid_in    = 1'b1;
    io_data_in_ch0 = 8'hA5;
    io_data_in_ch1 = 8'h5A;
    tick();
    tick();
    io_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lit_perr_en  = 1'b1; lit_perr  = 1'b1;
      lit_beat_en  = 1'b1; lit_beat  = 2'd0;
      lit_ready_en = 1'b1; lit_ready = 1'b0;
      tick();
    end
    core_ready_in = 1'b1;
    lit_data_en = 1'b1; lit_data = w[4];
    tick();
    lit_data_en = 1'b1; lit_data = w[5];
    lit_perr_en = 1'b1; lit_perr = 1'b1;
    tick();
    tick();

    // 5: reset mid-word
    send_beat(8'hDE, 8'hAD);
    send_beat(8'hBE, 8'hEF);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    lit_beat_en  = 1'b1; lit_beat  = 2'd0;
    lit_perr_en  = 1'b1; lit_perr  = 1'b0;
    lit_data_en  = 1'b1; lit_data  = 64'd0;
    lit_ready_en = 1'b1; lit_ready = 1'b1;
    tick();
    send_word(w[6]);
    lit_data_en = 1'b1; lit_data = w[6];
    tick();
    tick();

    // 6: full FIFO, pop and beat in the same cycle
    core_ready_in = 1'b0;
    send_word(w[7]);
    send_word(w[8]);
    core_ready_in  = 1'b1;
    io_valid_in    = 1'b1;
    io_data_in_ch0 = w[9][8*byte_pos(0, 0) +: 8];
    io_data_in_ch1 = w[9][8*byte_pos(0, 1) +: 8];
    lit_ready_en = 1'b1; lit_ready = 1'b0;
    lit_data_en  = 1'b1; lit_data  = w[7];
    tick();
    core_ready_in = 1'b0;
    lit_ready_en = 1'b1; lit_ready = 1'b1;
    lit_beat_en  = 1'b1; lit_beat  = 2'd0;
    tick();
    io_valid_in = 1'b0;
    lit_beat_en = 1'b1; lit_beat = 2'd1;
    lit_perr_en = 1'b1; lit_perr = 1'b1;
    tick();
    core_ready_in = 1'b1;
    for (int k = 1; k < 4; k++) begin
      send_beat(w[9][8*byte_pos(k, 0) +: 8], w[9][8*byte_pos(k, 1) +: 8]);
    end
    repeat (4) tick();

    // random phase
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 399) != 0);
      io_valid_in    = ($urandom_range(0, 3) != 0) &&
                       ((io_ready === 1'b1) || ($urandom_range(0, 15) == 0));
      io_data_in_ch0 = 8'($urandom());
      io_data_in_ch1 = 8'($urandom());
      core_ready_in  = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst           = 1'b1;
    io_valid_in   = 1'b0;
    core_ready_in = 1'b1;
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
